enc_ssd_driver: RTL and testbench

Downstream display stage for the Pmod rotary-encoder position counter. Takes the 5-bit encoder position, converts it to two decimal digits with a sequential subtract-by-ten converter, and time-multiplexes the digits onto a two-digit common-cathode Pmod SSD. Sits directly after the quadrature decoder on the same clock.

---
 rtl/enc_ssd_driver_if.sv | 22 ++
 rtl/enc_ssd_driver.sv | 129 ++++++++++++
 tb/tb_enc_ssd_driver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/enc_ssd_driver_if.sv
// Bundle between the encoder position source and the two-digit SSD driver.
// The source drives the position; the driver returns segment, digit-select and busy.
interface enc_ssd_driver_if;
  logic [4:0] EncIn;
  logic [6:0] Seg;
  logic       Cat;
  logic       Busy;

  modport master (
    output EncIn,
    input  Seg,
    input  Cat,
    input  Busy
  );

  modport slave (
    input  EncIn,
    output Seg,
    output Cat,
    output Busy
  );
endinterface

// File: rtl/enc_ssd_driver.sv
// Encoder position to two-digit multiplexed seven-segment display driver.
// Optional macro SSD_BLANK_ZERO_EN blanks the tens digit when it is zero.
module enc_ssd_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic              clk,
  input logic              BTN,
  enc_ssd_driver_if.slave  bus
);

  localparam int CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      work_q, work_d;
  logic [1:0]      tensCnt_q, tensCnt_d;
  logic [4:0]      shownVal_q, shownVal_d;
  logic [1:0]      dispTens_q, dispTens_d;
  logic [3:0]      dispOnes_q, dispOnes_d;
  logic [CntW-1:0] refreshCnt_q, refreshCnt_d;
  logic            cat_q, cat_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      digitSel;

  function automatic logic [6:0] decodeDigit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (BTN) begin
      state_q      <= IDLE;
      work_q       <= 5'd0;
      tensCnt_q    <= 2'd0;
      shownVal_q   <= 5'd0;
      dispTens_q   <= 2'd0;
      dispOnes_q   <= 4'd0;
      refreshCnt_q <= '0;
      cat_q        <= 1'b0;
      seg_q        <= 7'h3F;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      tensCnt_q    <= tensCnt_d;
      shownVal_q   <= shownVal_d;
      dispTens_q   <= dispTens_d;
      dispOnes_q   <= dispOnes_d;
      refreshCnt_q <= refreshCnt_d;
      cat_q        <= cat_d;
      seg_q        <= seg_d;
    end
  end

  // Repeated subtract-by-ten; EncIn is only sampled in IDLE, so a value that
  // changed mid-conversion is picked up on the first IDLE edge afterwards.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    tensCnt_d  = tensCnt_q;
    shownVal_d = shownVal_q;
    dispTens_d = dispTens_q;
    dispOnes_d = dispOnes_q;
    case (state_q)
      IDLE: begin
        if (bus.EncIn != shownVal_q) begin
          work_d     = bus.EncIn;
          shownVal_d = bus.EncIn;
          tensCnt_d  = 2'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (work_q >= 5'd10) begin
          work_d    = work_q - 5'd10;
          tensCnt_d = tensCnt_q + 2'd1;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dispTens_d = tensCnt_q;
        dispOnes_d = work_q[3:0];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segments are decoded from the next digit select so Seg and Cat move together.
  always_comb begin
    refreshCnt_d = refreshCnt_q + 1'b1;
    cat_d        = cat_q;
    if (refreshCnt_q == CntLast) begin
      refreshCnt_d = '0;
      cat_d        = ~cat_q;
    end
    digitSel = cat_d ? {2'b00, dispTens_q} : dispOnes_q;
    seg_d    = decodeDigit(digitSel);
`ifdef SSD_BLANK_ZERO_EN
    if (cat_d && (dispTens_q == 2'd0)) begin
      seg_d = 7'h00;
    end
`endif
  end

  assign bus.Seg  = seg_q;
  assign bus.Cat  = cat_q;
  assign bus.Busy = (state_q != IDLE);

endmodule

// File: tb/tb_enc_ssd_driver.sv
// Directed, table-driven bench for enc_ssd_driver with a short refresh period.
// Expected segment codes are hand-computed from the digit decode table.
module tb_enc_ssd_driver;

  localparam int RefreshDiv = 4;

`ifdef SSD_BLANK_ZERO_EN
  localparam logic [6:0] ZeroTens = 7'h00;
`else
  localparam logic [6:0] ZeroTens = 7'h3F;
`endif

  typedef struct {
    logic [4:0] encIn;
    int         busyCycles;
    logic [6:0] tensSeg;
    logic [6:0] onesSeg;
  } vec_t;

  logic clk;
  logic BTN;
  int   checks;
  int   errors;
  vec_t vecs[9];

  enc_ssd_driver_if bus ();

  enc_ssd_driver #(.REFRESH_DIV(RefreshDiv)) dut (
    .clk (clk),
    .BTN (BTN),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Counts Busy-high samples over a fixed window long enough for any conversion.
  task automatic countBusy(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b1) n++;
    end
  endtask

  // Captures the segment pattern shown in each digit over one full scan period.
  task automatic sampleDigits(output logic [6:0] tensSeg, output logic [6:0] onesSeg);
    tensSeg = 'x;
    onesSeg = 'x;
    for (int i = 0; i < 2 * RefreshDiv; i++) begin
      @(negedge clk);
      if (bus.Cat) tensSeg = bus.Seg;
      else         onesSeg = bus.Seg;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int busyN;
    logic [6:0] tSeg, oSeg;
    bus.EncIn = v.encIn;
    countBusy(busyN);
    checkOutput($sformatf("busy_cycles[%0d]", idx), busyN, v.busyCycles);
    sampleDigits(tSeg, oSeg);
    checkOutput($sformatf("tens_seg[%0d]", idx), int'(tSeg), int'(v.tensSeg));
    checkOutput($sformatf("ones_seg[%0d]", idx), int'(oSeg), int'(v.onesSeg));
  endtask

  initial begin
    int busyN;
    int gap;
    logic prevCat;
    logic [6:0] busyPat;
    logic [6:0] tSeg, oSeg;

    checks = 0;
    errors = 0;

    vecs[0] = '{encIn: 5'd7,  busyCycles: 2, tensSeg: ZeroTens, onesSeg: 7'h07};
    vecs[1] = '{encIn: 5'd19, busyCycles: 3, tensSeg: 7'h06,    onesSeg: 7'h6F};
    vecs[2] = '{encIn: 5'd0,  busyCycles: 2, tensSeg: ZeroTens, onesSeg: 7'h3F};
    vecs[3] = '{encIn: 5'd31, busyCycles: 5, tensSeg: 7'h4F,    onesSeg: 7'h06};
    vecs[4] = '{encIn: 5'd31, busyCycles: 0, tensSeg: 7'h4F,    onesSeg: 7'h06};
    vecs[5] = '{encIn: 5'd20, busyCycles: 4, tensSeg: 7'h5B,    onesSeg: 7'h3F};
    vecs[6] = '{encIn: 5'd12, busyCycles: 3, tensSeg: 7'h06,    onesSeg: 7'h5B};
    vecs[7] = '{encIn: 5'd28, busyCycles: 4, tensSeg: 7'h5B,    onesSeg: 7'h7F};
    vecs[8] = '{encIn: 5'd5,  busyCycles: 2, tensSeg: ZeroTens, onesSeg: 7'h6D};

    BTN = 1'b1;
    bus.EncIn = 5'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_seg", int'(bus.Seg), 'h3F);
    checkOutput("reset_cat", int'(bus.Cat), 0);
    checkOutput("reset_busy", int'(bus.Busy), 0);
    BTN = 1'b0;
    countBusy(busyN);
    checkOutput("busy_after_reset", busyN, 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Cat must hold for exactly RefreshDiv cycles per phase.
    prevCat = bus.Cat;
    gap = 0;
    while (bus.Cat === prevCat && gap < 3 * RefreshDiv) begin
      @(negedge clk);
      gap++;
    end
    for (int k = 0; k < 2; k++) begin
      prevCat = bus.Cat;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (bus.Cat === prevCat && gap < 3 * RefreshDiv);
      checkOutput($sformatf("cat_phase[%0d]", k), gap, RefreshDiv);
    end

    // 19 then 5 one cycle later: 19 finishes, one idle cycle, then 5 converts.
    bus.EncIn = 5'd19;
    busyPat = '0;
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      busyPat[i] = bus.Busy;
      bus.EncIn = 5'd5;
    end
    checkOutput("busy_19_then_5", int'(busyPat), 'b1110110);
    sampleDigits(tSeg, oSeg);
    checkOutput("tens_after_19_5", int'(tSeg), int'(ZeroTens));
    checkOutput("ones_after_19_5", int'(oSeg), 'h6D);

    // Reset during a conversion, then the held value is converted again.
    bus.EncIn = 5'd19;
    @(negedge clk);
    BTN = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", int'(bus.Busy), 0);
    checkOutput("midreset_seg", int'(bus.Seg), 'h3F);
    checkOutput("midreset_cat", int'(bus.Cat), 0);
    BTN = 1'b0;
    countBusy(busyN);
    checkOutput("midreset_reconv_busy", busyN, 3);
    sampleDigits(tSeg, oSeg);
    checkOutput("midreset_tens", int'(tSeg), 'h06);
    checkOutput("midreset_ones", int'(oSeg), 'h6F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
